// File: rtl/fetch_pkg.sv
// Shared types and constants for the PC fetch unit: FSM states, widths,
// load-source encodings and branch opcodes.
package fetch_pkg;

    localparam int PC_W = 10;
    localparam int IR_W = 18;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_EXEC  = 1'b1
    } state_t;

    localparam logic [1:0] MUX_IR    = 2'b00;
    localparam logic [1:0] MUX_STACK = 2'b01;
    localparam logic [1:0] MUX_INT   = 2'b10;
    localparam logic [1:0] MUX_ZERO  = 2'b11;

    // Branch opcodes are {IR[17:13], IR[1:0]}
    localparam logic [6:0] OP_BRN  = 7'd16;
    localparam logic [6:0] OP_BREQ = 7'd18;
    localparam logic [6:0] OP_BRNE = 7'd19;
    localparam logic [6:0] OP_BRCS = 7'd20;
    localparam logic [6:0] OP_BRCC = 7'd21;

endpackage

// File: rtl/fetch_branch_cond.sv
// Branch condition decode: true unless the opcode is a conditional branch
// whose flag test fails.
module fetch_branch_cond
    import fetch_pkg::*;
(
    input  logic [IR_W-1:0] ir_i,
    input  logic            c_flag_i,
    input  logic            z_flag_i,
    output logic            cond_o
);

    logic [6:0] opcode;

    assign opcode = {ir_i[17:13], ir_i[1:0]};

    always_comb begin
        cond_o = 1'b1;
        case (opcode)
            OP_BRN:  cond_o = 1'b1;
            OP_BREQ: cond_o = z_flag_i;
            OP_BRNE: cond_o = ~z_flag_i;
            OP_BRCS: cond_o = c_flag_i;
            OP_BRCC: cond_o = ~c_flag_i;
            default: cond_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Two-phase fetch/execute PC sequencer with conditional loads and stall.
// Optional interrupt entry (INT_REQ/INT_ACK/RET_PC) when FETCH_INT_EN is defined.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VECTOR = 10'h000,
    parameter logic [PC_W-1:0] INT_VECTOR   = 10'h3FF
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            PC_LD,
    input  logic            PC_INC,
    input  logic [1:0]      PC_MUX_SEL,
    input  logic [PC_W-1:0] FROM_STACK,
    input  logic            C_FLAG,
    input  logic            Z_FLAG,
    input  logic            STALL,
`ifdef FETCH_INT_EN
    input  logic            INT_REQ,
    output logic            INT_ACK,
    output logic [PC_W-1:0] RET_PC,
`endif
    output logic [PC_W-1:0] ROM_ADDR,
    input  logic [IR_W-1:0] ROM_DATA,
    output logic [IR_W-1:0] IR,
    output logic [PC_W-1:0] PC,
    output logic            EXEC,
    output logic            BR_TAKEN
);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [IR_W-1:0] ir_q, ir_d;
    logic            br_q, br_d;
    logic            cond;
    logic [PC_W-1:0] ld_src;
    logic [PC_W-1:0] pc_plus1;
    logic [PC_W-1:0] seq_pc;

    fetch_branch_cond u_cond (
        .ir_i     (ir_q),
        .c_flag_i (C_FLAG),
        .z_flag_i (Z_FLAG),
        .cond_o   (cond)
    );

    always_comb begin
        case (PC_MUX_SEL)
            MUX_IR:    ld_src = ir_q[12:3];
            MUX_STACK: ld_src = FROM_STACK;
            MUX_INT:   ld_src = INT_VECTOR;
            default:   ld_src = '0;
        endcase
    end

    assign pc_plus1 = pc_q + PC_W'(1);

    // A failed conditional load still advances, independent of PC_INC
    always_comb begin
        if (PC_LD)       seq_pc = cond ? ld_src : pc_plus1;
        else if (PC_INC) seq_pc = pc_plus1;
        else             seq_pc = pc_q;
    end

`ifdef FETCH_INT_EN
    logic            ack_q, ack_d;
    logic [PC_W-1:0] ret_q, ret_d;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        br_d    = 1'b0;
`ifdef FETCH_INT_EN
        ack_d   = 1'b0;
        ret_d   = ret_q;
`endif
        if (!STALL) begin
            case (state_q)
                ST_FETCH: begin
                    state_d = ST_EXEC;
                    ir_d    = ROM_DATA;
                end
                default: begin
                    state_d = ST_FETCH;
                    pc_d    = seq_pc;
                    br_d    = PC_LD & cond;
`ifdef FETCH_INT_EN
                    if (INT_REQ) begin
                        pc_d  = INT_VECTOR;
                        br_d  = 1'b0;
                        ack_d = 1'b1;
                        ret_d = seq_pc;
                    end
`endif
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_VECTOR;
            ir_q    <= '0;
            br_q    <= 1'b0;
`ifdef FETCH_INT_EN
            ack_q   <= 1'b0;
            ret_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            br_q    <= br_d;
`ifdef FETCH_INT_EN
            ack_q   <= ack_d;
            ret_q   <= ret_d;
`endif
        end
    end

    assign ROM_ADDR = pc_q;
    assign PC       = pc_q;
    assign IR       = ir_q;
    assign EXEC     = (state_q == ST_EXEC);
    assign BR_TAKEN = br_q & ~STALL;
`ifdef FETCH_INT_EN
    assign INT_ACK  = ack_q;
    assign RET_PC   = ret_q;
`endif

endmodule
